// File: rtl/gray_pkg.sv
// Gray-code helpers shared by the pointer encoder and the gray_to_binary decoder.
// Functions work on a fixed maximum width; narrower callers zero-extend and truncate.
package gray_pkg;

    localparam int GRAY_MIN_WIDTH = 2;
    localparam int GRAY_MAX_WIDTH = 32;

    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Leading zeros of a zero-extended code decode to zeros, so truncation is safe.
    function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] gray);
        logic [GRAY_MAX_WIDTH-1:0] bin;
        bin[GRAY_MAX_WIDTH-1] = gray[GRAY_MAX_WIDTH-1];
        for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/bin2gray_enc.sv
// Pure combinational binary-to-Gray encoder, WIDTH bits.
module bin2gray_enc
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(bin)));

endmodule

// File: rtl/gray_ptr_counter.sv
// Up/down pointer counter with a registered Gray copy for clock-domain crossing.
// gray_o is loaded from the encoded next value, never decoded from bin_o, so it cannot glitch.
module gray_ptr_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_o,
    output logic [WIDTH-1:0] gray_o,
    output logic [WIDTH-1:0] gray_next_o,
    output logic             wrap_o
);

    generate
        if (WIDTH < GRAY_MIN_WIDTH || WIDTH > GRAY_MAX_WIDTH) begin : g_width_check
            $error("gray_ptr_counter: WIDTH out of supported range");
        end
    endgenerate

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] next_bin;
    logic [WIDTH-1:0] next_gray;
    logic             next_wrap;

    // Load wins over inc/dec and never counts as a wrap; inc and dec together hold.
    always_comb begin
        next_bin  = bin_o;
        next_wrap = 1'b0;
        if (load) begin
            next_bin = load_val;
        end else if (inc && !dec) begin
            next_bin  = bin_o + ONE;
            next_wrap = (bin_o == ALL_ONES);
        end else if (dec && !inc) begin
            next_bin  = bin_o - ONE;
            next_wrap = (bin_o == '0);
        end
    end

    bin2gray_enc #(
        .WIDTH(WIDTH)
    ) u_enc (
        .bin  (next_bin),
        .gray (next_gray)
    );

    assign gray_next_o = next_gray;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_o  <= '0;
            gray_o <= '0;
            wrap_o <= 1'b0;
        end else begin
            bin_o  <= next_bin;
            gray_o <= next_gray;
            wrap_o <= next_wrap;
        end
    end

endmodule

// File: tb/tb_gray_ptr_counter.sv
// Directed and randomised checks of gray_ptr_counter at WIDTH=4.
module tb_gray_ptr_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         inc;
    logic         dec;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] bin_o;
    logic [W-1:0] gray_o;
    logic [W-1:0] gray_next_o;
    logic         wrap_o;

    int checks = 0;
    int errors = 0;

    gray_ptr_counter #(
        .WIDTH(W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc         (inc),
        .dec         (dec),
        .load        (load),
        .load_val    (load_val),
        .bin_o       (bin_o),
        .gray_o      (gray_o),
        .gray_next_o (gray_next_o),
        .wrap_o      (wrap_o)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic l, input logic [W-1:0] lv, input logic i, input logic d);
        load     = l;
        load_val = lv;
        inc      = i;
        dec      = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [W-1:0] b, input logic [W-1:0] g,
                             input logic w);
        check({tag, "_bin"}, 32'(bin_o), 32'(b));
        check({tag, "_gray"}, 32'(gray_o), 32'(g));
        check({tag, "_wrap"}, 32'(wrap_o), 32'(w));
    endtask

    logic [W-1:0] gray_seq [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                    4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    logic [W-1:0] model_bin;
    logic [W-1:0] exp_bin;
    logic [W-1:0] prev_gray;
    logic         exp_wrap;
    logic         r_load;
    logic         r_inc;
    logic         r_dec;
    logic [W-1:0] r_val;

    initial begin
        rst_n = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check_out("reset_async", 4'h0, 4'h0, 1'b0);

        // Unknown inputs while held in reset must not leak through.
        load = 1'bx; inc = 1'bx; dec = 1'bx; load_val = 'x;
        tick();
        tick();
        check_out("reset_x_inputs", 4'h0, 4'h0, 1'b0);

        drive(1'b0, '0, 1'b0, 1'b0);
        #3 rst_n = 1'b1;
        tick();
        check_out("release_idle", 4'h0, 4'h0, 1'b0);

        // Full increment cycle through all 16 Gray codes and back to zero.
        drive(1'b0, '0, 1'b1, 1'b0);
        prev_gray = 4'h0;
        for (int k = 1; k <= 16; k++) begin
            #1;
            check("inc_gray_next", 32'(gray_next_o), 32'(gray_seq[k % 16]));
            tick();
            check_out("inc_step", 4'(k % 16), gray_seq[k % 16], (k == 16));
            check("inc_onebit", $countones(prev_gray ^ gray_o), 1);
            prev_gray = gray_o;
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        check_out("after_wrap_hold", 4'h0, 4'h0, 1'b0);

        // Load beats a simultaneous increment.
        drive(1'b1, 4'b1011, 1'b1, 1'b0);
        tick();
        check_out("load_over_inc", 4'b1011, 4'b1110, 1'b0);

        // Decrement wrap from zero.
        drive(1'b1, 4'h0, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        check_out("dec_wrap", 4'b1111, 4'b1000, 1'b1);
        tick();
        check_out("dec_after_wrap", 4'b1110, 4'b1001, 1'b0);

        // Loading the wrapped value is not a wrap.
        drive(1'b1, 4'hF, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'h0, 1'b0, 1'b0);
        tick();
        check_out("load_no_wrap", 4'h0, 4'h0, 1'b0);

        // inc and dec together hold.
        drive(1'b1, 4'b0111, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_out("inc_dec_hold", 4'b0111, 4'b0100, 1'b0);
            check("inc_dec_gray_next", 32'(gray_next_o), 32'(4'b0100));
        end

        // Reset asserted between edges, then released with inc pending.
        drive(1'b1, 4'b0100, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        check_out("pre_reset", 4'b0101, 4'b0111, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_out("mid_cycle_reset", 4'h0, 4'h0, 1'b0);
        #1 rst_n = 1'b1;
        #1;
        check("release_gray_next", 32'(gray_next_o), 32'(4'b0001));
        tick();
        check_out("release_inc", 4'b0001, 4'b0001, 1'b0);

        // Randomised run against a reference model.
        drive(1'b1, 4'h0, 1'b0, 1'b0);
        tick();
        model_bin = 4'h0;
        for (int n = 0; n < 10000; n++) begin
            r_load = ($urandom_range(7) == 0);
            r_inc  = 1'($urandom_range(1));
            r_dec  = 1'($urandom_range(1));
            r_val  = 4'($urandom_range(15));
            drive(r_load, r_val, r_inc, r_dec);
            exp_wrap = 1'b0;
            if (r_load) begin
                exp_bin = r_val;
            end else if (r_inc && !r_dec) begin
                exp_bin  = 4'((int'(model_bin) + 1) % 16);
                exp_wrap = (model_bin == 4'hF);
            end else if (r_dec && !r_inc) begin
                exp_bin  = 4'((int'(model_bin) + 15) % 16);
                exp_wrap = (model_bin == 4'h0);
            end else begin
                exp_bin = model_bin;
            end
            #1;
            check("rnd_gray_next", 32'(gray_next_o), 32'(to_gray(exp_bin)));
            prev_gray = gray_o;
            tick();
            check_out("rnd", exp_bin, to_gray(exp_bin), exp_wrap);
            if (!r_load && (r_inc != r_dec)) begin
                check("rnd_onebit", $countones(prev_gray ^ gray_o), 1);
            end
            model_bin = exp_bin;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
